// File: rtl/battlecity_pkg.sv
// Shared types and constants for the keycode-to-tank-command path:
// facing directions, USB HID usage codes for both players and pause,
// fire state encoding, and a helper that maps a usage code to a direction.
package battlecity_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    FS_READY    = 2'b00,
    FS_COOL     = 2'b01,
    FS_WAIT_REL = 2'b10
  } fire_state_t;

  typedef struct packed {
    logic hit;
    dir_t dir;
  } dir_hit_t;

  localparam logic [7:0] KEY_NONE  = 8'h00;
  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_SPACE = 8'h2C;
  localparam logic [7:0] KEY_UP    = 8'h52;
  localparam logic [7:0] KEY_RIGHT = 8'h4F;
  localparam logic [7:0] KEY_DOWN  = 8'h51;
  localparam logic [7:0] KEY_LEFT  = 8'h50;
  localparam logic [7:0] KEY_ENTER = 8'h28;
  localparam logic [7:0] KEY_P     = 8'h13;

  // Map one usage code to a direction for player 1 (player2=0) or player 2.
  function automatic dir_hit_t decode_dir(input logic [7:0] code, input logic player2);
    dir_hit_t r;
    r.hit = 1'b1;
    r.dir = DIR_UP;
    if (!player2) begin
      case (code)
        KEY_W:   r.dir = DIR_UP;
        KEY_D:   r.dir = DIR_RIGHT;
        KEY_S:   r.dir = DIR_DOWN;
        KEY_A:   r.dir = DIR_LEFT;
        default: r.hit = 1'b0;
      endcase
    end else begin
      case (code)
        KEY_UP:    r.dir = DIR_UP;
        KEY_RIGHT: r.dir = DIR_RIGHT;
        KEY_DOWN:  r.dir = DIR_DOWN;
        KEY_LEFT:  r.dir = DIR_LEFT;
        default:   r.hit = 1'b0;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/key_cmd_decoder_player_cmd.sv
// Per-player command generator: latches facing/move and runs the shot
// cooldown state machine, all advancing only on frame_tick.
// Build option: AUTOFIRE_EN -- holding fire re-fires every COOLDOWN_FRAMES.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// FS_READY    | armed; a held fire key on the next tick produces a shot
// FS_COOL     | counting down frames since the last shot
// FS_WAIT_REL | cooldown done but key still held; wait for release
module player_cmd
  import battlecity_pkg::*;
#(
  parameter int COOLDOWN_FRAMES = 20
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_tick,
  input  logic       paused,
  input  logic       key_up,
  input  logic       key_right,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_fire,
  output logic [1:0] dir,
  output logic       move,
  output logic       fire
);

  localparam logic [7:0] CD_RELOAD = 8'(COOLDOWN_FRAMES - 1);

  dir_t        dir_q;
  fire_state_t state;
  logic [7:0]  cooldown;

  assign dir = dir_q;

  // Direction/move latch and fire FSM; fire is a one-Clk pulse after the tick.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      dir_q    <= DIR_UP;
      move     <= 1'b0;
      fire     <= 1'b0;
      state    <= FS_READY;
      cooldown <= 8'd0;
    end else begin
      fire <= 1'b0;
      if (frame_tick) begin
        if (paused) begin
          move <= 1'b0;
        end else begin
          move <= key_up | key_right | key_down | key_left;
          if (key_up)         dir_q <= DIR_UP;
          else if (key_right) dir_q <= DIR_RIGHT;
          else if (key_down)  dir_q <= DIR_DOWN;
          else if (key_left)  dir_q <= DIR_LEFT;

          case (state)
            FS_READY: begin
              if (key_fire) begin
                fire     <= 1'b1;
                cooldown <= CD_RELOAD;
`ifdef AUTOFIRE_EN
                state    <= FS_COOL;
`else
                // A one-frame cooldown has nothing to count; go check release.
                state    <= (COOLDOWN_FRAMES == 1) ? FS_WAIT_REL : FS_COOL;
`endif
              end
            end
            FS_COOL: begin
              if (cooldown != 8'd0) begin
                cooldown <= cooldown - 8'd1;
              end else if (key_fire) begin
`ifdef AUTOFIRE_EN
                fire     <= 1'b1;
                cooldown <= CD_RELOAD;
`else
                state    <= FS_WAIT_REL;
`endif
              end else begin
                state <= FS_READY;
              end
            end
            FS_WAIT_REL: begin
              if (!key_fire) state <= FS_READY;
            end
            default: state <= FS_READY;
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/key_cmd_decoder.sv
// Converts the two-slot HID keycode word from the Nios PIO into
// frame-synchronous tank commands for two players plus a pause level.
// Build option: AUTOFIRE_EN (passed through to player_cmd).
module key_cmd_decoder
  import battlecity_pkg::*;
#(
  parameter int COOLDOWN_FRAMES = 20,
  parameter int SYNC_STAGES     = 2
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [15:0] keycode,
  input  logic        frame_clk,
  output logic [1:0]  p1_dir,
  output logic        p1_move,
  output logic        p1_fire,
  output logic [1:0]  p2_dir,
  output logic        p2_move,
  output logic        p2_fire,
  output logic        paused
);

  logic [15:0]            key_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_prev;
  logic                   frame_tick;
  logic                   p_prev;
  logic                   paused_q;
  logic                   paused_nxt;
  logic [7:0]             slot0;
  logic [7:0]             slot1;
  logic                   p_now;
  dir_hit_t               p1_s0, p1_s1, p1_win;
  dir_hit_t               p2_s0, p2_s1, p2_win;
  logic                   p1_fire_key, p2_fire_key;

  // Keycode capture, frame_clk synchroniser and registered rising-edge tick.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      key_q      <= 16'h0000;
      sync_q     <= '0;
      sync_prev  <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      key_q      <= keycode;
      sync_q     <= {sync_q[SYNC_STAGES-2:0], frame_clk};
      sync_prev  <= sync_q[SYNC_STAGES-1];
      frame_tick <= sync_q[SYNC_STAGES-1] & ~sync_prev;
    end
  end

  assign slot0 = key_q[7:0];
  assign slot1 = key_q[15:8];

  // Slot 0 wins when both slots carry a direction for the same player, so
  // the per-player presence bits handed down are already one-hot.
  assign p1_s0  = decode_dir(slot0, 1'b0);
  assign p1_s1  = decode_dir(slot1, 1'b0);
  assign p2_s0  = decode_dir(slot0, 1'b1);
  assign p2_s1  = decode_dir(slot1, 1'b1);
  assign p1_win = p1_s0.hit ? p1_s0 : p1_s1;
  assign p2_win = p2_s0.hit ? p2_s0 : p2_s1;

  assign p1_fire_key = (slot0 == KEY_SPACE) | (slot1 == KEY_SPACE);
  assign p2_fire_key = (slot0 == KEY_ENTER) | (slot1 == KEY_ENTER);
  assign p_now       = (slot0 == KEY_P) | (slot1 == KEY_P);

  // The tick that toggles pause already obeys the new pause level.
  assign paused_nxt = paused_q ^ (p_now & ~p_prev);

  // Pause toggles on a P press seen between consecutive ticks.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      p_prev   <= 1'b0;
      paused_q <= 1'b0;
    end else if (frame_tick) begin
      p_prev   <= p_now;
      paused_q <= paused_nxt;
    end
  end

  assign paused = paused_q;

  player_cmd #(.COOLDOWN_FRAMES(COOLDOWN_FRAMES)) u_p1 (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .frame_tick (frame_tick),
    .paused     (paused_nxt),
    .key_up     (p1_win.hit && (p1_win.dir == DIR_UP)),
    .key_right  (p1_win.hit && (p1_win.dir == DIR_RIGHT)),
    .key_down   (p1_win.hit && (p1_win.dir == DIR_DOWN)),
    .key_left   (p1_win.hit && (p1_win.dir == DIR_LEFT)),
    .key_fire   (p1_fire_key),
    .dir        (p1_dir),
    .move       (p1_move),
    .fire       (p1_fire)
  );

  player_cmd #(.COOLDOWN_FRAMES(COOLDOWN_FRAMES)) u_p2 (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .frame_tick (frame_tick),
    .paused     (paused_nxt),
    .key_up     (p2_win.hit && (p2_win.dir == DIR_UP)),
    .key_right  (p2_win.hit && (p2_win.dir == DIR_RIGHT)),
    .key_down   (p2_win.hit && (p2_win.dir == DIR_DOWN)),
    .key_left   (p2_win.hit && (p2_win.dir == DIR_LEFT)),
    .key_fire   (p2_fire_key),
    .dir        (p2_dir),
    .move       (p2_move),
    .fire       (p2_fire)
  );

endmodule
